// File: rtl/host_fifo_bridge_pkg.sv
// Shared definitions for the host-to-FIFO bridge: register offsets,
// STATUS/CTRL bit positions and the read-sequencer state encoding.
package host_fifo_bridge_pkg;

  localparam logic [7:0] REG_TX_DATA = 8'h00;
  localparam logic [7:0] REG_RX_DATA = 8'h04;
  localparam logic [7:0] REG_STATUS  = 8'h08;
  localparam logic [7:0] REG_CTRL    = 8'h0C;
  localparam logic [7:0] REG_COUNTS  = 8'h10;

  localparam int STATUS_IN_FULL   = 0;
  localparam int STATUS_OUT_EMPTY = 1;
  localparam int STATUS_OVERFLOW  = 2;
  localparam int STATUS_UNDERFLOW = 3;
  localparam int STATUS_PROTO_ERR = 4;

  localparam int CTRL_CLR_STICKY = 0;
  localparam int CTRL_CLR_COUNTS = 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RD_POP = 2'd1,
    ST_RD_CAP = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

endpackage

// File: rtl/host_fifo_bridge_regs.sv
// Status/count register bank: sticky error flags, push/pop counters and
// the combinational read mux for the non-FIFO registers.
module host_fifo_bridge_regs
  import host_fifo_bridge_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  tx_inc,
  input  logic                  rx_inc,
  input  logic                  set_overflow,
  input  logic                  set_underflow,
  input  logic                  set_proto_err,
  input  logic                  clr_sticky,
  input  logic                  clr_counts,
  input  logic                  in_full,
  input  logic                  out_empty,
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic        overflow;
  logic        underflow;
  logic        proto_err;
  logic [15:0] tx_count;
  logic [15:0] rx_count;
  logic [31:0] rd_word;

  // Sticky flags: a set in the same cycle as a CTRL clear wins.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      if (set_overflow)       overflow  <= 1'b1;
      else if (clr_sticky)    overflow  <= 1'b0;
      if (set_underflow)      underflow <= 1'b1;
      else if (clr_sticky)    underflow <= 1'b0;
      if (set_proto_err)      proto_err <= 1'b1;
      else if (clr_sticky)    proto_err <= 1'b0;
    end
  end

  // Push/pop counters, 16-bit free-running with natural wrap.
  always_ff @(posedge clock) begin
    if (reset || clr_counts) begin
      tx_count <= '0;
      rx_count <= '0;
    end else begin
      if (tx_inc) tx_count <= tx_count + 16'd1;
      if (rx_inc) rx_count <= rx_count + 16'd1;
    end
  end

  // Read mux for STATUS and COUNTS; every other offset reads as zero.
  always_comb begin
    // NOTE: default every combinational output first so no path infers a latch.
    rd_word = '0;
    if (addr == ADDR_WIDTH'(REG_STATUS)) begin
      rd_word[STATUS_IN_FULL]   = in_full;
      rd_word[STATUS_OUT_EMPTY] = out_empty;
      rd_word[STATUS_OVERFLOW]  = overflow;
      rd_word[STATUS_UNDERFLOW] = underflow;
      rd_word[STATUS_PROTO_ERR] = proto_err;
    end else if (addr == ADDR_WIDTH'(REG_COUNTS)) begin
      rd_word = {tx_count, rx_count};
    end
  end

  assign rd_data = DATA_WIDTH'(rd_word);

endmodule

// File: rtl/host_fifo_bridge.sv
// Host register interface bridging to a push FIFO (TX) and a pop FIFO (RX).
// Writes and register reads complete in one cycle; RX reads run a short
// pop/capture/respond sequence during which the host is told to wait.
module host_fifo_bridge
  import host_fifo_bridge_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  host_wr,
  input  logic                  host_rd,
  input  logic [ADDR_WIDTH-1:0] host_addr,
  input  logic [DATA_WIDTH-1:0] host_wdata,
  output logic [DATA_WIDTH-1:0] host_rdata,
  output logic                  host_rvalid,
  output logic                  host_wack,
  output logic                  host_busy,
  input  logic                  in_full,
  output logic                  in_wr,
  output logic [DATA_WIDTH-1:0] in_dout,
  input  logic                  out_empty,
  output logic                  out_rd,
  input  logic [DATA_WIDTH-1:0] out_din
);

  state_e state, state_next;

  logic                  is_tx, is_rx, is_ctrl;
  logic                  wr_accept, push, overflow_evt;
  logic                  quick_rd, underflow_evt, capture, proto_evt;
  logic [DATA_WIDTH-1:0] mux_data;

  assign is_tx   = (host_addr == ADDR_WIDTH'(REG_TX_DATA));
  assign is_rx   = (host_addr == ADDR_WIDTH'(REG_RX_DATA));
  assign is_ctrl = (host_addr == ADDR_WIDTH'(REG_CTRL));

  assign host_busy = (state != ST_IDLE);
  assign out_rd    = (state == ST_RD_POP);

  // Read-sequencer state register.
  always_ff @(posedge clock) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Strobe acceptance and next state; only IDLE takes new strobes.
  always_comb begin
    state_next    = state;
    wr_accept     = 1'b0;
    quick_rd      = 1'b0;
    underflow_evt = 1'b0;
    capture       = 1'b0;
    proto_evt     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (host_wr) begin
          wr_accept = 1'b1;
          proto_evt = host_rd;          // simultaneous read is dropped
        end else if (host_rd) begin
          if (is_rx && !out_empty) begin
            state_next = ST_RD_POP;
          end else begin
            quick_rd      = 1'b1;
            underflow_evt = is_rx;
          end
        end
      end
      ST_RD_POP: begin
        state_next = ST_RD_CAP;
        proto_evt  = host_wr | host_rd;
      end
      ST_RD_CAP: begin
        state_next = ST_RESP;
        capture    = 1'b1;
        proto_evt  = host_wr | host_rd;
      end
      ST_RESP: begin
        state_next = ST_IDLE;
        proto_evt  = host_wr | host_rd;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign push         = wr_accept && is_tx && !in_full;
  assign overflow_evt = wr_accept && is_tx && in_full;

  // Registered host responses and FIFO push; rdata holds between responses.
  always_ff @(posedge clock) begin
    if (reset) begin
      in_wr       <= 1'b0;
      in_dout     <= '0;
      host_wack   <= 1'b0;
      host_rvalid <= 1'b0;
      host_rdata  <= '0;
    end else begin
      in_wr       <= push;
      host_wack   <= wr_accept;
      host_rvalid <= quick_rd | capture;
      if (push)          in_dout    <= host_wdata;
      if (quick_rd)      host_rdata <= mux_data;
      else if (capture)  host_rdata <= out_din;
    end
  end

  host_fifo_bridge_regs #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_regs (
    .clock        (clock),
    .reset        (reset),
    .tx_inc       (push),
    .rx_inc       (capture),
    .set_overflow (overflow_evt),
    .set_underflow(underflow_evt),
    .set_proto_err(proto_evt),
    .clr_sticky   (wr_accept && is_ctrl && host_wdata[CTRL_CLR_STICKY]),
    .clr_counts   (wr_accept && is_ctrl && host_wdata[CTRL_CLR_COUNTS]),
    .in_full      (in_full),
    .out_empty    (out_empty),
    .addr         (host_addr),
    .rd_data      (mux_data)
  );

endmodule

// File: tb/tb_host_fifo_bridge.sv
// Self-checking bench for host_fifo_bridge: directed scenarios plus a
// randomized phase, all checked against a transaction-level register model.
module tb_host_fifo_bridge;

  localparam int DW = 32;
  localparam int AW = 8;

  logic          clock = 1'b0;
  logic          reset;
  logic          host_wr, host_rd;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata, host_rdata;
  logic          host_rvalid, host_wack, host_busy;
  logic          in_full, in_wr;
  logic [DW-1:0] in_dout;
  logic          out_empty, out_rd;
  logic [DW-1:0] out_din;

  int checks = 0;
  int errors = 0;

  // Transaction-level model of the visible register state.
  logic [15:0] m_tx, m_rx;
  logic        m_ovf, m_unf, m_perr;
  logic [31:0] m_rdata;

  host_fifo_bridge #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clock(clock), .reset(reset),
    .host_wr(host_wr), .host_rd(host_rd), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_rdata(host_rdata),
    .host_rvalid(host_rvalid), .host_wack(host_wack), .host_busy(host_busy),
    .in_full(in_full), .in_wr(in_wr), .in_dout(in_dout),
    .out_empty(out_empty), .out_rd(out_rd), .out_din(out_din)
  );

  always #5 clock = ~clock;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_tx = '0; m_rx = '0; m_ovf = 1'b0; m_unf = 1'b0; m_perr = 1'b0; m_rdata = '0;
  endtask

  function automatic logic [31:0] model_reg(input logic [7:0] a);
    case (a)
      8'h08:   return {27'd0, m_perr, m_unf, m_ovf, out_empty, in_full};
      8'h10:   return {m_tx, m_rx};
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_write(input logic [7:0] a, input logic [31:0] d, input logic full);
    if (a == 8'h00) begin
      if (full) m_ovf = 1'b1;
      else      m_tx  = m_tx + 16'd1;
    end
    if (a == 8'h0C) begin
      if (d[0]) begin m_ovf = 1'b0; m_unf = 1'b0; m_perr = 1'b0; end
      if (d[1]) begin m_tx = '0; m_rx = '0; end
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_in_wr"},  32'(in_wr), 0);
    check({tag, "_out_rd"}, 32'(out_rd), 0);
    check({tag, "_wack"},   32'(host_wack), 0);
    check({tag, "_rvalid"}, 32'(host_rvalid), 0);
    check({tag, "_busy"},   32'(host_busy), 0);
    check({tag, "_in_dout"}, in_dout, 0);
    check({tag, "_rdata"},  host_rdata, 0);
  endtask

  task automatic do_write(input logic [7:0] a, input logic [31:0] d, input logic full);
    logic push;
    @(negedge clock);
    host_wr = 1'b1; host_addr = a; host_wdata = d; in_full = full;
    push = (a == 8'h00) && !full;
    @(posedge clock); #1;
    host_wr = 1'b0;
    check("wr_wack", 32'(host_wack), 1);
    check("wr_in_wr", 32'(in_wr), 32'(push));
    if (push) check("wr_in_dout", in_dout, d);
    check("wr_no_rvalid", 32'(host_rvalid), 0);
    model_write(a, d, full);
    @(posedge clock); #1;
    check("wr_wack_single", 32'(host_wack), 0);
    check("wr_in_wr_single", 32'(in_wr), 0);
  endtask

  task automatic do_read(input logic [7:0] a, input logic empty, input logic [31:0] din);
    logic [31:0] exp;
    @(negedge clock);
    host_rd = 1'b1; host_addr = a; out_empty = empty; out_din = ~din;
    exp = model_reg(a);
    @(posedge clock); #1;
    host_rd = 1'b0;
    if (a == 8'h04 && !empty) begin
      check("rx_out_rd", 32'(out_rd), 1);
      check("rx_busy_pop", 32'(host_busy), 1);
      check("rx_rvalid_early", 32'(host_rvalid), 0);
      @(posedge clock); #1;
      out_din = din;
      check("rx_out_rd_single", 32'(out_rd), 0);
      check("rx_busy_cap", 32'(host_busy), 1);
      check("rx_rvalid_cap", 32'(host_rvalid), 0);
      @(posedge clock); #1;
      out_din = ~din;
      check("rx_rvalid", 32'(host_rvalid), 1);
      check("rx_rdata", host_rdata, din);
      m_rx = m_rx + 16'd1;
      m_rdata = din;
    end else begin
      if (a == 8'h04) begin m_unf = 1'b1; exp = 32'd0; end
      check("rd_out_rd_none", 32'(out_rd), 0);
      check("rd_rvalid", 32'(host_rvalid), 1);
      check("rd_rdata", host_rdata, exp);
      check("rd_not_busy", 32'(host_busy), 0);
      m_rdata = exp;
    end
    @(posedge clock); #1;
    check("rd_rvalid_single", 32'(host_rvalid), 0);
    check("rd_rdata_hold", host_rdata, m_rdata);
    check("rd_idle_busy", 32'(host_busy), 0);
  endtask

  task automatic do_wr_rd(input logic [7:0] a, input logic [31:0] d);
    logic push;
    @(negedge clock);
    host_wr = 1'b1; host_rd = 1'b1; host_addr = a; host_wdata = d; in_full = 1'b0;
    push = (a == 8'h00);
    @(posedge clock); #1;
    host_wr = 1'b0; host_rd = 1'b0;
    check("wrrd_wack", 32'(host_wack), 1);
    check("wrrd_in_wr", 32'(in_wr), 32'(push));
    check("wrrd_no_rvalid", 32'(host_rvalid), 0);
    model_write(a, d, 1'b0);
    m_perr = 1'b1;
    @(posedge clock); #1;
    check("wrrd_no_rvalid_late", 32'(host_rvalid), 0);
  endtask

  initial begin
    logic [7:0]  addrs [6];
    logic [7:0]  a;
    logic [31:0] d;
    addrs = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14};
    reset = 1'b1; host_wr = 1'b0; host_rd = 1'b0; host_addr = '0; host_wdata = '0;
    in_full = 1'b0; out_empty = 1'b1; out_din = '0;
    model_reset();
    repeat (3) @(posedge clock);
    #1;
    check_all_zero("reset");
    @(negedge clock);
    reset = 1'b0;

    // Single push and the counter it bumps.
    do_write(8'h00, 32'h0000_0005, 1'b0);
    do_read(8'h10, 1'b1, 32'h0);
    check("counts_after_push", host_rdata, 32'h0001_0000);

    // RX pop with data present.
    do_read(8'h04, 1'b0, 32'h0000_0007);

    // Underflow, then sticky clear.
    do_read(8'h04, 1'b1, 32'h1234_5678);
    do_read(8'h08, 1'b1, 32'h0);
    check("status_underflow", host_rdata & 32'h8, 32'h8);
    do_write(8'h0C, 32'h1, 1'b0);
    do_read(8'h08, 1'b1, 32'h0);
    check("status_underflow_cleared", host_rdata & 32'h8, 32'h0);

    // Overflow: no push, count unchanged.
    do_write(8'h00, 32'hCAFE_F00D, 1'b1);
    do_read(8'h08, 1'b0, 32'h0);
    do_read(8'h10, 1'b0, 32'h0);

    // Strobe during a busy RX read is ignored and flagged.
    in_full = 1'b0;
    @(negedge clock);
    host_rd = 1'b1; host_addr = 8'h04; out_empty = 1'b0; out_din = ~32'h0BAD_BEEF;
    @(posedge clock); #1;
    host_rd = 1'b0;
    check("busy_out_rd", 32'(out_rd), 1);
    @(negedge clock);
    host_wr = 1'b1; host_addr = 8'h00; host_wdata = 32'hDEAD_0001;
    @(posedge clock); #1;
    host_wr = 1'b0; out_din = 32'h0BAD_BEEF;
    check("busy_no_push", 32'(in_wr), 0);
    check("busy_no_wack", 32'(host_wack), 0);
    @(posedge clock); #1;
    check("busy_rvalid", 32'(host_rvalid), 1);
    check("busy_rdata", host_rdata, 32'h0BAD_BEEF);
    m_rx = m_rx + 16'd1; m_perr = 1'b1; m_rdata = 32'h0BAD_BEEF;
    @(posedge clock); #1;
    check("busy_done", 32'(host_busy), 0);
    do_read(8'h08, 1'b1, 32'h0);

    // Protocol error set and CTRL clear in the same cycle: set wins.
    do_wr_rd(8'h0C, 32'h1);
    do_read(8'h08, 1'b1, 32'h0);
    check("set_wins_perr", host_rdata & 32'h1C, 32'h10);

    // Randomized mix of register traffic.
    for (int i = 0; i < 200; i++) begin
      a = addrs[$urandom_range(0, 5)];
      d = $urandom;
      if ($urandom_range(0, 1) == 0) begin
        if (a == 8'h0C && $urandom_range(0, 3) != 0) d = d & 32'hFFFF_FFFC;
        do_write(a, d, 1'($urandom_range(0, 1)));
      end else begin
        do_read(a, 1'($urandom_range(0, 1)), d);
      end
    end

    // Counter wrap: preload tx_count to 0xFFFF with back-to-back pushes.
    do_write(8'h0C, 32'h2, 1'b0);
    @(negedge clock);
    host_wr = 1'b1; host_addr = 8'h00; host_wdata = 32'hA5A5_A5A5; in_full = 1'b0;
    repeat (65535) @(negedge clock);
    host_wr = 1'b0;
    m_tx = m_tx + 16'hFFFF;
    do_read(8'h10, 1'b1, 32'h0);
    check("counts_preload", host_rdata, 32'hFFFF_0000);
    do_write(8'h00, 32'h0000_0011, 1'b0);
    do_read(8'h10, 1'b1, 32'h0);
    check("counts_wrap", host_rdata, 32'h0000_0000);
    do_wr_rd(8'h00, 32'h0000_0022);
    do_read(8'h08, 1'b1, 32'h0);
    check("status_perr", host_rdata & 32'h10, 32'h10);

    // Reset during RD_CAP abandons the read.
    @(negedge clock);
    host_rd = 1'b1; host_addr = 8'h04; out_empty = 1'b0; out_din = 32'h0000_0099;
    @(posedge clock); #1;
    host_rd = 1'b0;
    @(posedge clock); #1;
    check("rst_cap_busy", 32'(host_busy), 1);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock); #1;
    check_all_zero("rst_cap");
    model_reset();
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock); #1;
    check("rst_cap_no_rvalid", 32'(host_rvalid), 0);
    do_read(8'h10, 1'b1, 32'h0);
    check("rst_cap_counts", host_rdata, 32'h0);

    // Reset beats a simultaneous strobe.
    do_write(8'h00, 32'h0000_0033, 1'b0);
    @(negedge clock);
    reset = 1'b1; host_wr = 1'b1; host_rd = 1'b1; host_addr = 8'h00; host_wdata = 32'h77;
    @(posedge clock); #1;
    check_all_zero("rst_strobe");
    @(negedge clock);
    reset = 1'b0; host_wr = 1'b0; host_rd = 1'b0;
    model_reset();
    do_read(8'h08, 1'b1, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
